// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_4_if.sv
// Control and status bundle for the programmable divided-clock generator.
//   EN   : run request (master -> slave)
//   LD   : ratio load strobe (master -> slave)
//   DIV  : ratio code, half-period = DIV+1 source cycles (master -> slave)
//   Y    : registered 50%-duty divided clock (slave -> master)
//   TICK : one-cycle pulse on the first cycle of each Y high phase (slave -> master)
//   BUSY : a loaded ratio is waiting to be applied (slave -> master)
interface gf180mcu_osu_sc_gp9t3v3__clkdiv_4_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             LD;
  logic [WIDTH-1:0] DIV;
  logic             Y;
  logic             TICK;
  logic             BUSY;

  modport master (output EN, LD, DIV, input Y, TICK, BUSY);
  modport slave  (input EN, LD, DIV, output Y, TICK, BUSY);
endinterface

// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_4.sv
// Programmable glitch-free divided-clock generator.
// Produces a registered 50%-duty clock Y with half-period ratio+1 CLK cycles.
// Ratio changes are held pending and applied only at a full-period boundary
// (end of a low phase) or when starting from idle, so no runt phases appear.
// Ports:
//   CLK : source clock, all state updates on its rising edge
//   R   : synchronous active-high reset
//   bus : slave side of the control/status bundle (EN, LD, DIV, Y, TICK, BUSY)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | stopped, Y low, waiting for EN
// S_HIGH | Y high for ratio+1 cycles, EN ignored until phase ends
// S_LOW  | Y low for ratio+1 cycles, period boundary at its last cycle
module gf180mcu_osu_sc_gp9t3v3__clkdiv_4 #(
  parameter int WIDTH = 4
) (
  input  logic CLK,
  input  logic R,
  gf180mcu_osu_sc_gp9t3v3__clkdiv_4_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pvalid_q, pvalid_d;
  logic             y_q, y_d;
  logic             tick_q, tick_d;
  logic             apply;

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q  <= S_IDLE;
      ratio_q  <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      pvalid_q <= 1'b0;
      y_q      <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ratio_q  <= ratio_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      pvalid_q <= pvalid_d;
      y_q      <= y_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ratio_d  = ratio_q;
    pend_d   = pend_q;
    pvalid_d = pvalid_q;
    cnt_d    = cnt_q;
    apply    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.EN) begin
          apply   = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt_q == ratio_q) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LOW: begin
        if (cnt_q == ratio_q) begin
          cnt_d   = '0;
          apply   = 1'b1;
          state_d = bus.EN ? S_HIGH : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Apply uses the pending value from before this edge; a simultaneous
    // load then becomes the new pending value and keeps BUSY asserted.
    if (apply && pvalid_q) begin
      ratio_d  = pend_q;
      pvalid_d = 1'b0;
    end
    if (bus.LD) begin
      pend_d   = bus.DIV;
      pvalid_d = 1'b1;
    end

    // Outputs are registered from next-state so Y/TICK come straight from flops.
    y_d    = (state_d == S_HIGH);
    tick_d = (state_d == S_HIGH) && (cnt_d == '0);
  end

  assign bus.Y    = y_q;
  assign bus.TICK = tick_q;
  assign bus.BUSY = pvalid_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_4.sv
module tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_4;

  logic clk = 1'b0;
  logic r;
  int   checks   = 0;
  int   failures = 0;

  gf180mcu_osu_sc_gp9t3v3__clkdiv_4_if #(.WIDTH(4)) bus ();

  gf180mcu_osu_sc_gp9t3v3__clkdiv_4 #(.WIDTH(4)) dut (
    .CLK (clk),
    .R   (r),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: tracks level, remaining cycles of the current phase,
  // and the active/pending ratio. Evaluated on each rising edge.
  bit m_valid = 0;
  bit m_run   = 0;
  bit m_y     = 0;
  bit m_tick  = 0;
  bit m_pv    = 0;
  int m_ratio = 0;
  int m_pend  = 0;
  int m_left  = 0;

  always @(posedge clk) begin
    if (r) begin
      m_valid = 1; m_run = 0; m_y = 0; m_tick = 0;
      m_pv = 0; m_ratio = 0; m_pend = 0; m_left = 0;
    end else if (m_valid) begin
      m_tick = 0;
      if (!m_run) begin
        if (bus.EN) begin
          if (m_pv) begin m_ratio = m_pend; m_pv = 0; end
          m_run = 1; m_y = 1; m_tick = 1; m_left = m_ratio;
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (m_y) begin
        m_y = 0; m_left = m_ratio;
      end else begin
        if (m_pv) begin m_ratio = m_pend; m_pv = 0; end
        if (bus.EN) begin
          m_y = 1; m_tick = 1; m_left = m_ratio;
        end else begin
          m_run = 0;
        end
      end
      if (bus.LD) begin m_pend = int'(bus.DIV); m_pv = 1; end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl_y",    bus.Y,    m_y);
      chk("mdl_tick", bus.TICK, m_tick);
      chk("mdl_busy", bus.BUSY, m_pv);
    end
  end

  task automatic cyc();
    @(negedge clk);
    bus.LD = 1'b0;
  endtask

  // Steps n cycles; patterns are read MSB-first (leftmost bit = first cycle).
  task automatic check_seq(input string name, input int n, input logic [31:0] yp,
                           input logic [31:0] tp, input logic [31:0] bp);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk($sformatf("%s_y%0d", name, i), bus.Y,    yp[n-1-i]);
      chk($sformatf("%s_t%0d", name, i), bus.TICK, tp[n-1-i]);
      chk($sformatf("%s_b%0d", name, i), bus.BUSY, bp[n-1-i]);
    end
  endtask

  task automatic chk3(input string name, input logic y, input logic t, input logic b);
    chk({name, "_y"}, bus.Y, y);
    chk({name, "_t"}, bus.TICK, t);
    chk({name, "_b"}, bus.BUSY, b);
  endtask

  task automatic do_reset();
    bus.EN = 1'b0; r = 1'b1;
    cyc();
    r = 1'b0;
  endtask

  initial begin
    r = 1'b1; bus.EN = 1'b0; bus.LD = 1'b0; bus.DIV = '0;
    cyc();
    chk3("reset", 1'b0, 1'b0, 1'b0);
    cyc();

    // never-loaded ratio: CLK/2
    r = 1'b0; bus.EN = 1'b1;
    check_seq("div0", 8, 8'b10101010, 8'b10101010, 8'b0);

    // load DIV=2 in idle, then run
    do_reset();
    bus.LD = 1'b1; bus.DIV = 4'd2;
    cyc();
    chk3("ld_idle", 1'b0, 1'b0, 1'b1);
    bus.EN = 1'b1;
    check_seq("div2", 13, 13'b1110001110001, 13'b1000001000001, 13'b0);

    // reload DIV=0 mid high phase
    cyc();
    bus.LD = 1'b1; bus.DIV = 4'd0;
    cyc();
    chk3("ld_run", 1'b1, 1'b0, 1'b1);
    check_seq("chg", 7, 7'b0001010, 7'b0001010, 7'b1110000);

    // stop at DIV=3
    do_reset();
    bus.LD = 1'b1; bus.DIV = 4'd3;
    cyc();
    bus.EN = 1'b1;
    cyc();
    chk3("start3", 1'b1, 1'b1, 1'b0);
    bus.EN = 1'b0;
    check_seq("stop", 10, 10'b1110000000, 10'b0, 10'b0);
    bus.EN = 1'b1;
    cyc();
    chk3("restart", 1'b1, 1'b1, 1'b0);

    // two loads in one period, last wins
    bus.LD = 1'b1; bus.DIV = 4'd5;
    cyc();
    cyc();
    bus.LD = 1'b1; bus.DIV = 4'd1;
    cyc();
    chk("ld2_busy", bus.BUSY, 1'b1);
    check_seq("ld2", 8, 8'b00001100, 8'b00001000, 8'b11110000);

    // load coinciding with the apply edge
    bus.LD = 1'b1; bus.DIV = 4'd3;
    cyc();
    cyc(); cyc(); cyc();
    bus.LD = 1'b1; bus.DIV = 4'd0;
    cyc();
    chk3("coinc", 1'b1, 1'b1, 1'b1);
    check_seq("coinc", 9, 9'b111000010, 9'b000000010, 9'b111111100);

    // maximum ratio: CLK/32
    do_reset();
    bus.LD = 1'b1; bus.DIV = 4'd15;
    cyc();
    bus.EN = 1'b1;
    check_seq("max", 32, 32'hFFFF0000, 32'h80000000, 32'h0);

    // reset mid high phase with a pending load
    do_reset();
    bus.LD = 1'b1; bus.DIV = 4'd4;
    cyc();
    bus.EN = 1'b1;
    cyc();
    bus.LD = 1'b1; bus.DIV = 4'd7;
    cyc();
    chk3("pre_r", 1'b1, 1'b0, 1'b1);
    r = 1'b1;
    cyc();
    chk3("mid_r", 1'b0, 1'b0, 1'b0);
    r = 1'b0;
    check_seq("post_r", 6, 6'b101010, 6'b101010, 6'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
